// File: rtl/hybridarith_pkg.sv
// Shared definitions for the hybrid add/subtract datapath.
// Holds the operand width, the 2/4/2 segment split and the pipeline stage
// payload types used by hybridsub8_pipe.
package hybridarith_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LO_W   = 2;  // low ripple segment, bits [1:0]
    localparam int unsigned LA_W   = 4;  // lookahead segment, bits [5:2]
    localparam int unsigned HI_W   = 2;  // high ripple segment, bits [7:6]

    // Stage 1 payload. Operand bits [1:0] are already consumed by the low
    // ripple, so only the upper bits travel on.
    typedef struct packed {
        logic [DATA_W-1:LO_W] x_up;
        logic [DATA_W-1:LO_W] y_up;
        logic [LO_W-1:0]      d_lo;
        logic                 b2;
    } s1_t;

    // Stage 2 payload. The operand sign bits X7/Y7 are the top bits of
    // x_hi/y_hi.
    typedef struct packed {
        logic [HI_W-1:0]      x_hi;
        logic [HI_W-1:0]      y_hi;
        logic [LO_W+LA_W-1:0] d_lo;
        logic                 b6;
    } s2_t;

endpackage

// File: rtl/borrow_lookahead4.sv
// Four-bit borrow-lookahead block.
// Every borrow is a flat two-level sum of products over p/g and the
// incoming borrow, so there is no ripple path through the segment.
// Ports:
//   p_i  [3:0]  borrow-propagate, p = ~(x ^ y)
//   g_i  [3:0]  borrow-generate,  g = ~x & y
//   b_i         borrow into bit 0 of the segment
//   b_o  [4:1]  borrow into bits 1..4 (b_o[4] leaves the segment)
module borrow_lookahead4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       b_i,
    output logic [4:1] b_o
);

    assign b_o[1] = g_i[0]
                  | (p_i[0] & b_i);

    assign b_o[2] = g_i[1]
                  | (p_i[1] & g_i[0])
                  | (p_i[1] & p_i[0] & b_i);

    assign b_o[3] = g_i[2]
                  | (p_i[2] & g_i[1])
                  | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & b_i);

    assign b_o[4] = g_i[3]
                  | (p_i[3] & g_i[2])
                  | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                  | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & b_i);

endmodule

// File: rtl/hybridsub8_pipe.sv
// Three-stage pipelined 8-bit subtractor, D = X - Y - Bin.
// Stage 1 ripples bits [1:0], stage 2 resolves bits [5:2] by lookahead,
// stage 3 ripples bits [7:6] and forms borrow-out and signed overflow.
// Valid/ready handshake on both sides; every stage is a skid-free register
// that advances when the stage after it can take its contents.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   a beat can be accepted this cycle
//   Xi, Yi     minuend, subtrahend
//   Bin        borrow-in
//   out_valid  result valid
//   out_ready  consumer takes the result this cycle
//   Di         difference, mod 256
//   Bout       unsigned borrow-out (X < Y + Bin)
//   V          signed overflow
module hybridsub8_pipe #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Xi,
    input  logic [DATA_W-1:0] Yi,
    input  logic              Bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Di,
    output logic              Bout,
    output logic              V
);

    import hybridarith_pkg::*;

    if (DATA_W != hybridarith_pkg::DATA_W) begin : g_width_check
        $error("hybridsub8_pipe: DATA_W must be 8");
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic valid1_q, valid1_d;
    logic valid2_q, valid2_d;
    logic out_valid_q, out_valid_d;
    logic ready1, ready2, ready3;
    logic load1, load2, load3;

    assign ready3 = ~out_valid_q | out_ready;
    assign ready2 = ~valid2_q | ready3;
    assign ready1 = ~valid1_q | ready2;

    assign load1 = in_valid & ready1;
    assign load2 = valid1_q & ready2;
    assign load3 = valid2_q & ready3;

    // A ready stage takes whatever sits upstream, including a bubble.
    assign valid1_d    = ready1 ? in_valid : valid1_q;
    assign valid2_d    = ready2 ? valid1_q : valid2_q;
    assign out_valid_d = ready3 ? valid2_q : out_valid_q;

    assign in_ready = ready1;

    // ------------------------------------------------------------------
    // Stage 1: ripple-borrow over bits [1:0]
    // ------------------------------------------------------------------
    s1_t              s1_q, s1_d;
    logic [LO_W:0]    lo_b;
    logic [LO_W-1:0]  lo_d;

    always_comb begin
        lo_b    = '0;
        lo_d    = '0;
        lo_b[0] = Bin;
        for (int i = 0; i < int'(LO_W); i++) begin
            lo_d[i]   = Xi[i] ^ Yi[i] ^ lo_b[i];
            lo_b[i+1] = (~Xi[i] & Yi[i]) | (~(Xi[i] ^ Yi[i]) & lo_b[i]);
        end
    end

    always_comb begin
        s1_d      = s1_q;
        if (load1) begin
            s1_d.x_up = Xi[DATA_W-1:LO_W];
            s1_d.y_up = Yi[DATA_W-1:LO_W];
            s1_d.d_lo = lo_d;
            s1_d.b2   = lo_b[LO_W];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: lookahead over bits [5:2]
    // ------------------------------------------------------------------
    s2_t              s2_q, s2_d;
    logic [LA_W-1:0]  la_x, la_y, la_p, la_g, la_d;
    logic [LA_W:1]    la_b;
    logic [LA_W-1:0]  la_bin;  // borrow into each lookahead bit

    assign la_x = s1_q.x_up[LO_W+LA_W-1:LO_W];
    assign la_y = s1_q.y_up[LO_W+LA_W-1:LO_W];
    assign la_p = ~(la_x ^ la_y);
    assign la_g = ~la_x & la_y;

    borrow_lookahead4 u_borrow_lookahead4 (
        .p_i (la_p),
        .g_i (la_g),
        .b_i (s1_q.b2),
        .b_o (la_b)
    );

    assign la_bin = {la_b[LA_W-1:1], s1_q.b2};
    assign la_d   = la_x ^ la_y ^ la_bin;

    always_comb begin
        s2_d = s2_q;
        if (load2) begin
            s2_d.x_hi = s1_q.x_up[DATA_W-1:LO_W+LA_W];
            s2_d.y_hi = s1_q.y_up[DATA_W-1:LO_W+LA_W];
            s2_d.d_lo = {la_d, s1_q.d_lo};
            s2_d.b6   = la_b[LA_W];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: ripple-borrow over bits [7:6], borrow-out and overflow
    // ------------------------------------------------------------------
    logic [HI_W:0]     hi_b;
    logic [HI_W-1:0]   hi_d;
    logic [DATA_W-1:0] di_q, di_d, diff;
    logic              bout_q, bout_d;
    logic              v_q, v_d;
    logic              x_sign, y_sign;

    always_comb begin
        hi_b    = '0;
        hi_d    = '0;
        hi_b[0] = s2_q.b6;
        for (int i = 0; i < int'(HI_W); i++) begin
            hi_d[i]   = s2_q.x_hi[i] ^ s2_q.y_hi[i] ^ hi_b[i];
            hi_b[i+1] = (~s2_q.x_hi[i] & s2_q.y_hi[i])
                      | (~(s2_q.x_hi[i] ^ s2_q.y_hi[i]) & hi_b[i]);
        end
    end

    assign x_sign = s2_q.x_hi[HI_W-1];
    assign y_sign = s2_q.y_hi[HI_W-1];
    assign diff   = {hi_d, s2_q.d_lo};

    always_comb begin
        di_d   = di_q;
        bout_d = bout_q;
        v_d    = v_q;
        if (load3) begin
            di_d   = diff;
            bout_d = hi_b[HI_W];
            // Overflow only when signs differ and the result sign left X's.
            v_d    = (x_sign ^ y_sign) & (diff[DATA_W-1] ^ x_sign);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q    <= 1'b0;
            valid2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            di_q        <= '0;
            bout_q      <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            valid1_q    <= valid1_d;
            valid2_q    <= valid2_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            di_q        <= di_d;
            bout_q      <= bout_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Di        = di_q;
    assign Bout      = bout_q;
    assign V         = v_q;

endmodule

// File: tb/tb_hybridsub8_pipe.sv
// Self-checking bench for hybridsub8_pipe: directed vector table, backpressure
// and mid-flight reset sequences, then a randomised stream against a model.
module tb_hybridsub8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Xi;
    logic [7:0] Yi;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Di;
    logic       Bout;
    logic       V;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hybridsub8_pipe #(
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xi        (Xi),
        .Yi        (Yi),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Di        (Di),
        .Bout      (Bout),
        .V         (V)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       v;
    } vec_t;

    vec_t vecs [10];

    logic [16:0] sb_q [$];  // {x, y, bin} of accepted beats, oldest first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Returns {V, Bout, D} from plain wide and signed integer arithmetic.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y,
                                           input logic b);
        logic [8:0] r;
        int         sx, sy, sd;
        logic       v;
        r  = {1'b0, x} - {1'b0, y} - {8'b0, b};
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy - (b ? 1 : 0);
        v  = (sd < -128) || (sd > 127);
        return {v, r};
    endfunction

    task automatic run_vec(input int idx, input vec_t vv);
        int cyc;
        @(negedge clk);
        Xi        = vv.x;
        Yi        = vv.y;
        Bin       = vv.bin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("vec%0d_latency", idx), 32'(cyc), 32'd3);
        check($sformatf("vec%0d_result", idx), {22'b0, V, Bout, Di},
              {22'b0, vv.v, vv.bout, vv.d});
    endtask

    initial begin
        int   seen;
        logic [9:0]  exp;
        logic [16:0] beat;
        logic [7:0]  bp_x [4];
        logic [7:0]  bp_y [4];
        logic [7:0]  bp_d [4];

        //            x      y      bin   d      bout  v
        vecs[0] = {8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = {8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = {8'h40, 8'h01, 1'b1, 8'h3E, 1'b0, 1'b0};
        vecs[4] = {8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = {8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = {8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[8] = {8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[9] = {8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Xi        = 8'h00;
        Yi        = 8'h00;
        Bin       = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_outputs", {22'b0, V, Bout, Di}, 32'd0);

        // Directed table
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Drain the last result
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: four beats offered with the consumer stalled
        bp_x = '{8'h10, 8'h20, 8'h30, 8'h40};
        bp_y = '{8'h01, 8'h02, 8'h03, 8'h04};
        bp_d = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            Xi       = bp_x[k];
            Yi       = bp_y[k];
            Bin      = 1'b0;
            in_valid = 1'b1;
            #1;
            check($sformatf("bp_in_ready_beat%0d", k), 32'(in_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        check("bp_full_head_valid", 32'(out_valid), 32'd1);
        check("bp_full_head_data", 32'(Di), 32'(bp_d[0]));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_data", k), {23'b0, Bout, Di}, 32'(bp_d[0]));
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        // Release: the held fourth beat gets in on the same edge the head leaves
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out0", 32'(Di), 32'(bp_d[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("bp_out%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_out%0d_data", k), 32'(Di), 32'(bp_d[k]));
        end
        @(negedge clk);
        #1;
        check("bp_no_extra_output", 32'(out_valid), 32'd0);

        // Reset with two beats in flight
        @(negedge clk);
        Xi = 8'h55; Yi = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        Xi = 8'h66; Yi = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_nothing_emitted", 32'(seen), 32'd0);

        // Random streaming with random bubbles and stalls
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            Xi        = 8'($urandom);
            Yi        = 8'($urandom);
            Bin       = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rand_unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    beat = sb_q.pop_front();
                    exp  = ref_sub(beat[16:9], beat[8:1], beat[0]);
                    check("rand_result", {22'b0, V, Bout, Di}, {22'b0, exp});
                end
            end
            if (in_valid && in_ready) sb_q.push_back({Xi, Yi, Bin});
        end

        // Drain with a bounded wait
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("drain_unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    beat = sb_q.pop_front();
                    exp  = ref_sub(beat[16:9], beat[8:1], beat[0]);
                    check("drain_result", {22'b0, V, Bout, Di}, {22'b0, exp});
                end
            end
            @(negedge clk);
        end
        check("drain_all_emitted", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hybridsub8_pipe.md
Name: hybridsub8_pipe

Overview:
- Pipelined 8-bit subtractor computing D = X - Y - Bin.
- Inverse-direction counterpart of the 8-bit hybrid adder. Uses the same 2/4/2 bit split: ripple-borrow on bits [1:0], borrow-lookahead on bits [5:2], ripple-borrow on bits [7:6].
- Each segment is one pipeline stage. Valid/ready handshakes on input and output, so it drops into the streaming datapath beside the adder.

Parameters:
- DATA_W, 8, operand width. Only 8 is legal; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- Xi  input  8  minuend
- Yi  input  8  subtrahend
- Bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- Di  output  8  difference X - Y - Bin, mod 256
- Bout  output  1  unsigned borrow-out (1 when X < Y + Bin)
- V  output  1  signed overflow

Behaviour:
- Reset: synchronous, active-high; one clock cycle with rst=1 suffices.
  - Stage valid flags, out_valid, Di, Bout and V all clear to 0.
  - in_ready reads 1 on the first cycle after reset is released.
  - Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Per-bit terms:
  - Borrow-generate g_i = ~X_i & Y_i.
  - Borrow-propagate p_i = ~(X_i ^ Y_i).
  - B_(i+1) = g_i | (p_i & B_i).
  - D_i = X_i ^ Y_i ^ B_i.
  - B_0 = Bin.
- Stage 1 (accept): on in_valid & in_ready, register Xi, Yi, D[1:0] (ripple from Bin) and B2.
- Stage 2: lookahead over bits [5:2] from the registered B2.
  - All of B3..B6 are two-level sum-of-products in p/g/B2; no ripple chain.
  - Registers D[5:2] and B6, and forwards X[7:6], Y[7:6], X7, Y7 and D[1:0].
- Stage 3 (output): ripple bits [7:6] from B6; registers Di, Bout = B8, and V = (X7 ^ Y7) & (Di[7] ^ X7).
- Handshake:
  - Each stage k holds valid_k.
  - ready_3 = ~out_valid | out_ready.
  - ready_k = ~valid_k | ready_(k+1).
  - in_ready = ready_1.
  - A stage loads when its upstream is valid and it is ready; it otherwise holds its data unchanged.
- Latency: 3 cycles from the accepting edge to out_valid, when unstalled.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0 the pipe fills to 3 beats, then in_ready drops combinationally that cycle.
  - No beat is lost or duplicated; order is preserved.
- Output stability: Di, Bout and V are stable while out_valid=1 and out_ready=0.
- Simultaneous accept on a full pipe with out_ready=1: legal. All stages shift and a new beat is taken in the same cycle.
- in_valid=0 cycles create bubbles; bubbles collapse when downstream stalls.
- Wrap-around: results are mod 256. Bout flags unsigned underflow and V flags signed overflow, independently.

Decomposition:
- Shared package hybridarith_pkg holds:
  - DATA_W = 8
  - LO_W = 2 (low ripple segment width)
  - LA_W = 4 (lookahead segment width)
  - HI_W = 2 (high ripple segment width)
  - Stage payload struct typedefs
- One sub-module, borrow_lookahead4: combinational, inputs p[3:0], g[3:0], bin; outputs b[4:1]. Instantiated in stage 2.
- Ripple segments and the handshake logic stay inline in hybridsub8_pipe.

Test Plan:
- Basic: X=0x05, Y=0x03, Bin=0, out_ready=1 -> 3 cycles later Di=0x02, Bout=0, V=0.
- Underflow: X=0x03, Y=0x05 -> Di=0xFE, Bout=1, V=0. Separately X=0x00, Y=0x00, Bin=1 -> Di=0xFF, Bout=1, V=0.
- Lookahead chain: X=0x40, Y=0x01, Bin=1 (borrow travels B2 through B6) -> Di=0x3E, Bout=0. Also X=0x80, Y=0x01 -> Di=0x7F, Bout=0, V=1.
- Backpressure:
  - Hold out_ready=0 while offering 4 beats (0x10-0x01, 0x20-0x02, 0x30-0x03, 0x40-0x04) -> 3 accepted, in_ready=0 on the 4th.
  - Head result 0x0F is held stable.
  - Release out_ready -> 0x0F, 0x1E, 0x2D, 0x3C emitted in order, one per cycle.
- Reset mid-operation: 2 beats in flight, rst=1 for 1 cycle -> out_valid=0 and in_ready=1 afterwards; neither beat is ever emitted.
- Random streaming: 10k random X, Y, Bin with random in_valid/out_ready -> every result matches the reference model {Bout, Di} = {1'b0,X} - {1'b0,Y} - Bin (Bout is the 9th result bit); V matches the signed check; order is preserved.
